display_scan_ctrl: RTL

- Parametrised successor to the calculator's 4-digit display driver.
- Converts a W-bit result to BCD with a sequential double-dabble, one bit per cycle.
- Time-multiplexes an NPHY-digit common-anode 7-segment display and applies leading-zero blanking, a minus sign, and an "Err" pattern.
- Lets the user scroll an NPHY-wide window across ND BCD digits with but0.
- Sits between the calculator core (result, error, load strobe) and the board LEDs.

---
 rtl/display_scan_ctrl_pkg.sv | 50 +++++
 rtl/bin2bcd_seq.sv | 56 +++++
 rtl/display_scan_ctrl.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/display_scan_ctrl_pkg.sv
// Shared definitions for the display scan controller: FSM states,
// active-low 7-segment patterns ({dp,g,f,e,d,c,b,a}) and sizing helpers.
package display_scan_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_SHOW = 2'd2,
        ST_ERR  = 2'd3
    } state_t;

    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_MINUS = 8'hBF;
    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_E     = 8'h86;
    localparam logic [7:0] SEG_R     = 8'hAF;

    function automatic logic [7:0] seg_digit(input logic [3:0] d);
        case (d)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction

    // Decimal digits of 2^w - 1 is floor(w*log10(2)) + 1, since 2^w is never a power of ten.
    function automatic int bcd_digits_needed(input int w, input bit is_signed);
        if (is_signed)
            return ((w - 1) * 30103) / 100000 + 2;
        return (w * 30103) / 100000 + 1;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: converts a W-bit unsigned value to ND BCD digits,
// one shift-plus-add-3 iteration per clock, W iterations per conversion.
module bin2bcd_seq #(
    parameter int W  = 24,
    parameter int ND = 8
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            start,
    input  logic [W-1:0]    bin,
    output logic [4*ND-1:0] bcd,
    output logic            busy,
    output logic            done
);

    localparam int CNT_W = $clog2(W + 1);

    logic [W-1:0]     shreg;
    logic [CNT_W-1:0] cnt;
    logic [4*ND-1:0]  adj;

    always_comb begin
        adj = bcd;
        for (int d = 0; d < ND; d++) begin
            if (bcd[4*d +: 4] >= 4'd5)
                adj[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            shreg <= '0;
            cnt   <= '0;
            bcd   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                shreg <= bin;
                bcd   <= '0;
                cnt   <= '0;
                busy  <= 1'b1;
            end else if (busy) begin
                bcd   <= {adj[4*ND-2:0], shreg[W-1]};
                shreg <= shreg << 1;
                cnt   <= cnt + CNT_W'(1);
                if (cnt == CNT_W'(W - 1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/display_scan_ctrl.sv
// Multiplexed common-anode 7-segment driver: BCD conversion, leading-zero
// blanking, minus sign, "Err" pattern and a but0-scrolled window of NPHY digits.
module display_scan_ctrl
    import display_scan_ctrl_pkg::*;
#(
    parameter int W           = 24,
    parameter int ND          = 8,
    parameter int NPHY        = 4,
    parameter int REFRESH_DIV = 100000,
    parameter bit SIGNED      = 1'b1
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            load,
    input  logic [W-1:0]    i_val,
    input  logic            error,
    input  logic            but0,
    output logic [NPHY-1:0] led_active,
    output logic [7:0]      led_code,
    output logic            error_led,
    output logic            busy,
    output logic            done
);

    localparam int OFF_W   = $clog2(ND + 1);
    localparam int SCAN_W  = (NPHY > 1) ? $clog2(NPHY) : 1;
    localparam int RC_W    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int OFF_MAX = ND - NPHY;

    if (ND < bcd_digits_needed(W, SIGNED)) begin : g_nd_check
        $error("display_scan_ctrl: ND too small to hold every value of i_val");
    end
    if (NPHY < 1 || NPHY > ND) begin : g_nphy_check
        $error("display_scan_ctrl: NPHY must satisfy 1 <= NPHY <= ND");
    end
    if (REFRESH_DIV < 1) begin : g_div_check
        $error("display_scan_ctrl: REFRESH_DIV must be at least 1");
    end

    state_t              state, state_nxt;
    logic                accept, start_conv, in_neg, neg;
    logic signed [W-1:0] val_s;
    logic [W-1:0]        mag;
    logic                but_sync0, but_sync1, but_prev, but_rise;
    logic [OFF_W-1:0]    offset;
    logic [SCAN_W-1:0]   scan_idx;
    logic [RC_W-1:0]     refresh;
    logic [4*ND-1:0]     bcd;
    logic                bcd_busy, bcd_done;
    logic [NPHY-1:0]     led_active_d;
    logic [7:0]          led_code_d;
    logic [3:0]          cur_digit;
    int                  digit_j, msd;

    assign accept     = load && (state != ST_CONV);
    assign start_conv = accept && !error;
    assign val_s      = i_val;
    assign in_neg     = (SIGNED != 1'b0) && i_val[W-1];
    // Negating the most negative value wraps to exactly its unsigned magnitude.
    assign mag        = in_neg ? $unsigned(-val_s) : i_val;
    assign but_rise   = but_sync1 && !but_prev;
    assign busy       = bcd_busy;

    bin2bcd_seq #(
        .W  (W),
        .ND (ND)
    ) u_bcd (
        .CLK   (CLK),
        .RST   (RST),
        .start (start_conv),
        .bin   (mag),
        .bcd   (bcd),
        .busy  (bcd_busy),
        .done  (bcd_done)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (accept)
            state_nxt = error ? ST_ERR : ST_CONV;
        else if (state == ST_CONV && bcd_done)
            state_nxt = ST_SHOW;
    end

    always_comb begin
        led_active_d = '1;
        led_code_d   = SEG_BLANK;
        digit_j      = int'(offset) + int'(scan_idx);
        msd          = 0;
        cur_digit    = 4'd0;
        for (int d = 0; d < ND; d++) begin
            if (bcd[4*d +: 4] != 4'd0)
                msd = d;
            if (d == digit_j)
                cur_digit = bcd[4*d +: 4];
        end
        case (state)
            ST_SHOW: begin
                led_active_d[scan_idx] = 1'b0;
                if (digit_j <= msd)
                    led_code_d = seg_digit(cur_digit);
                else if (digit_j == msd + 1 && neg)
                    led_code_d = SEG_MINUS;
            end
            ST_ERR: begin
                led_active_d[scan_idx] = 1'b0;
                if (int'(scan_idx) < 2)
                    led_code_d = SEG_R;
                else if (int'(scan_idx) == 2)
                    led_code_d = SEG_E;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            but_sync0  <= 1'b0;
            but_sync1  <= 1'b0;
            but_prev   <= 1'b0;
            neg        <= 1'b0;
            error_led  <= 1'b0;
            done       <= 1'b0;
            offset     <= '0;
            refresh    <= '0;
            scan_idx   <= '0;
            led_active <= '1;
            led_code   <= SEG_BLANK;
        end else begin
            but_sync0 <= but0;
            but_sync1 <= but_sync0;
            but_prev  <= but_sync1;
            done      <= 1'b0;
            if (accept) begin
                error_led <= error;
                done      <= error;
                offset    <= '0;
                if (!error)
                    neg <= in_neg;
            end else if (state == ST_CONV && bcd_done) begin
                done <= 1'b1;
            end else if (state == ST_SHOW && but_rise) begin
                offset <= (offset == OFF_W'(OFF_MAX)) ? '0 : offset + OFF_W'(1);
            end

            if (state == ST_SHOW || state == ST_ERR) begin
                if (refresh == RC_W'(REFRESH_DIV - 1)) begin
                    refresh  <= '0;
                    scan_idx <= (scan_idx == SCAN_W'(NPHY - 1)) ? '0 : scan_idx + SCAN_W'(1);
                end else begin
                    refresh <= refresh + RC_W'(1);
                end
            end else begin
                refresh  <= '0;
                scan_idx <= '0;
            end

            led_active <= led_active_d;
            led_code   <= led_code_d;
        end
    end

endmodule
